// File: rtl/pipe_nodatahazards_mem_pkg.sv
// Shared widths and the EX/MEM bundle
// for the memory-access stage.
package pipe_nodatahazards_mem_pkg;

  localparam int DATA_W   = 32;
  localparam int REGNUM_W = 5;

  typedef struct packed {
    logic                wreg;
    logic                m2reg;
    logic                wmem;
    logic                st_hz;
    logic [REGNUM_W-1:0] wn;
    logic [DATA_W-1:0]   alu;
    logic [DATA_W-1:0]   qb;
  } ex_mem_t;

endpackage

// File: rtl/pipe_EX_MEM_reg.sv
// EX/MEM pipeline register with
// synchronous active-low clear.
module pipe_EX_MEM_reg
  import pipe_nodatahazards_mem_pkg::*;
(
  input  logic    clk,
  input  logic    clrn,
  input  ex_mem_t d_i,
  output ex_mem_t q_o
);

  ex_mem_t q_q;

  always_ff @(posedge clk) begin
    if (!clrn) q_q <= '0;
    else       q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_dmem.sv
// Word-addressed data RAM: synchronous
// write, asynchronous read.
module pipe_dmem
  import pipe_nodatahazards_mem_pkg::*;
#(
  parameter int DMEM_AW = 5
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [DMEM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DMEM_AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pipe_nodatahazards_mem.sv
// MEM stage: EX/MEM register, data RAM
// and the load-then-store operand mux.
module pipe_nodatahazards_mem
  import pipe_nodatahazards_mem_pkg::*;
#(
  parameter int DMEM_AW = 5
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                EXwreg,
  input  logic                EXm2reg,
  input  logic                EXwmem,
  input  logic                EXisStoreHazards,
  input  logic [REGNUM_W-1:0] EXwn,
  input  logic [DATA_W-1:0]   EXaluResult,
  input  logic [DATA_W-1:0]   EXqb,
  input  logic [DATA_W-1:0]   WBdata,
  output logic                MEMwreg,
  output logic                MEMm2reg,
  output logic [REGNUM_W-1:0] MEMwn,
  output logic [DATA_W-1:0]   MEMaluResult,
  output logic [DATA_W-1:0]   MEMmemData
);

  ex_mem_t ex_d;
  ex_mem_t mem_q;
  logic [DATA_W-1:0]  store_data;
  logic [DMEM_AW-1:0] widx;
  logic               we;

  assign ex_d = '{
    wreg:  EXwreg,
    m2reg: EXm2reg,
    wmem:  EXwmem,
    st_hz: EXisStoreHazards,
    wn:    EXwn,
    alu:   EXaluResult,
    qb:    EXqb
  };

  pipe_EX_MEM_reg u_reg (
    .clk  (clk),
    .clrn (clrn),
    .d_i  (ex_d),
    .q_o  (mem_q)
  );

  // The preceding load is in WB now, so its
  // result replaces the stale ID operand.
  assign store_data = mem_q.st_hz ? WBdata : mem_q.qb;
  assign widx       = mem_q.alu[DMEM_AW+1:2];
  assign we         = mem_q.wmem & clrn;

  pipe_dmem #(
    .DMEM_AW (DMEM_AW)
  ) u_dmem (
    .clk     (clk),
    .we_i    (we),
    .addr_i  (widx),
    .wdata_i (store_data),
    .rdata_o (MEMmemData)
  );

  assign MEMwreg      = mem_q.wreg;
  assign MEMm2reg     = mem_q.m2reg;
  assign MEMwn        = mem_q.wn;
  assign MEMaluResult = mem_q.alu;

endmodule

// File: tb/tb_pipe_nodatahazards_mem.sv
// Table-driven and randomized checks of
// the MEM stage against a reference model.
module tb_pipe_nodatahazards_mem;

  logic        clk = 1'b0;
  logic        clrn;
  logic        EXwreg, EXm2reg, EXwmem, EXisStoreHazards;
  logic [4:0]  EXwn;
  logic [31:0] EXaluResult, EXqb, WBdata;
  logic        MEMwreg, MEMm2reg;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult, MEMmemData;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_nodatahazards_mem #(.DMEM_AW(5)) dut (
    .clk              (clk),
    .clrn             (clrn),
    .EXwreg           (EXwreg),
    .EXm2reg          (EXm2reg),
    .EXwmem           (EXwmem),
    .EXisStoreHazards (EXisStoreHazards),
    .EXwn             (EXwn),
    .EXaluResult      (EXaluResult),
    .EXqb             (EXqb),
    .WBdata           (WBdata),
    .MEMwreg          (MEMwreg),
    .MEMm2reg         (MEMm2reg),
    .MEMwn            (MEMwn),
    .MEMaluResult     (MEMaluResult),
    .MEMmemData       (MEMmemData)
  );

  typedef struct {
    logic        clrn;
    logic        wreg, m2reg, wmem, hz;
    logic [4:0]  wn;
    logic [31:0] alu, qb, wb;
    logic        e_wreg, e_m2reg;
    logic [4:0]  e_wn;
    logic [31:0] e_alu, e_mdata;
  } vec_t;

  // Reference: a 32-word array plus the one
  // instruction currently sitting in MEM.
  logic [31:0] m_mem [32];
  logic        m_wreg, m_m2reg, m_wmem, m_hz;
  logic [4:0]  m_wn;
  logic [31:0] m_alu, m_qb;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 32);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic model_edge();
    if (clrn) begin
      if (m_wmem)
        m_mem[widx(m_alu)] = m_hz ? WBdata : m_qb;
      m_wreg  = EXwreg;
      m_m2reg = EXm2reg;
      m_wmem  = EXwmem;
      m_hz    = EXisStoreHazards;
      m_wn    = EXwn;
      m_alu   = EXaluResult;
      m_qb    = EXqb;
    end else begin
      m_wreg = 0; m_m2reg = 0; m_wmem = 0;
      m_hz = 0; m_wn = 0; m_alu = 0; m_qb = 0;
    end
  endtask

  task automatic apply(input vec_t v);
    clrn             = v.clrn;
    EXwreg           = v.wreg;
    EXm2reg          = v.m2reg;
    EXwmem           = v.wmem;
    EXisStoreHazards = v.hz;
    EXwn             = v.wn;
    EXaluResult      = v.alu;
    EXqb             = v.qb;
    WBdata           = v.wb;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic c, w, m, s, h,
    input logic [4:0] wn,
    input logic [31:0] alu, qb, wb,
    input logic ew, em,
    input logic [4:0] ewn,
    input logic [31:0] ealu, ed);
    vec_t v;
    v.clrn = c; v.wreg = w; v.m2reg = m;
    v.wmem = s; v.hz = h; v.wn = wn;
    v.alu = alu; v.qb = qb; v.wb = wb;
    v.e_wreg = ew; v.e_m2reg = em;
    v.e_wn = ewn; v.e_alu = ealu; v.e_mdata = ed;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_wreg = 0; m_m2reg = 0; m_wmem = 0;
    m_hz = 0; m_wn = 0; m_alu = 0; m_qb = 0;
    clrn = 0; EXwreg = 0; EXm2reg = 0; EXwmem = 0;
    EXisStoreHazards = 0; EXwn = 0;
    EXaluResult = 0; EXqb = 0; WBdata = 0;

    // reset with a store request present
    tbl.push_back(mk(0,0,0,1,0,0,32'h4,32'hDEAD,0,
                     0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,32'h4,32'hDEAD,0,
                     0,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,32'h4,0,0,
                     0,1,0,32'h4,0));
    // plain store then load
    tbl.push_back(mk(1,0,0,1,0,0,32'h8,32'h12345678,0,
                     0,0,0,32'h8,0));
    tbl.push_back(mk(1,0,1,0,0,0,32'h8,0,0,
                     0,1,0,32'h8,32'h12345678));
    // store hazard: WBdata wins over qb
    tbl.push_back(mk(1,0,0,1,1,0,32'hC,32'h1111,0,
                     0,0,0,32'hC,0));
    tbl.push_back(mk(1,0,1,0,0,0,32'hC,0,32'hCAFEF00D,
                     0,1,0,32'hC,32'hCAFEF00D));
    // pass-through
    tbl.push_back(mk(1,1,0,0,0,17,32'hFFFF0001,0,0,
                     1,0,17,32'hFFFF0001,0));
    // wrap and misalign: 0x83 -> word 0
    tbl.push_back(mk(1,0,0,1,0,0,32'h83,32'hA5A5A5A5,0,
                     0,0,0,32'h83,0));
    tbl.push_back(mk(1,0,1,0,0,0,32'h0,0,0,
                     0,1,0,32'h0,32'hA5A5A5A5));
    // reset kills a queued store
    tbl.push_back(mk(1,1,0,1,0,5,32'h10,32'hBEEF,0,
                     1,0,5,32'h10,0));
    tbl.push_back(mk(0,1,0,0,0,9,32'h14,0,0,
                     0,0,0,0,32'hA5A5A5A5));
    tbl.push_back(mk(1,0,1,0,0,0,32'h10,0,0,
                     0,1,0,32'h10,0));
    tbl.push_back(mk(1,0,1,0,0,0,32'hC,0,0,
                     0,1,0,32'hC,32'hCAFEF00D));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      chk($sformatf("t%0d.wreg", i),
          32'(MEMwreg), 32'(tbl[i].e_wreg));
      chk($sformatf("t%0d.m2reg", i),
          32'(MEMm2reg), 32'(tbl[i].e_m2reg));
      chk($sformatf("t%0d.wn", i),
          32'(MEMwn), 32'(tbl[i].e_wn));
      chk($sformatf("t%0d.alu", i),
          MEMaluResult, tbl[i].e_alu);
      chk($sformatf("t%0d.mdata", i),
          MEMmemData, tbl[i].e_mdata);
    end

    for (int k = 0; k < 400; k++) begin
      vec_t v;
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = a & 32'h0000_00FF;
      v = mk(($urandom_range(0, 15) != 0),
             1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom),
             5'($urandom), a, $urandom, $urandom,
             0, 0, 0, 0, 0);
      apply(v);
      chk("r.wreg", 32'(MEMwreg), 32'(m_wreg));
      chk("r.m2reg", 32'(MEMm2reg), 32'(m_m2reg));
      chk("r.wn", 32'(MEMwn), 32'(m_wn));
      chk("r.alu", MEMaluResult, m_alu);
      chk("r.mdata", MEMmemData, m_mem[widx(m_alu)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
